// File: rtl/rip_mem_access.sv
// RV32I load/store unit: one request at a time, lane steering for stores,
// extraction and sign/zero extension for loads, and misalignment/funct3 checks.
module rip_mem_access #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 32
) (
    input  logic                    clk,
    input  logic                    rstn,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic                    req_we,
    input  logic [2:0]              req_funct3,
    input  logic [ADDR_WIDTH-1:0]   req_addr,
    input  logic [DATA_WIDTH-1:0]   req_wdata,
    output logic                    mem_we,
    output logic                    mem_re,
    output logic [ADDR_WIDTH-1:0]   mem_addr,
    output logic [DATA_WIDTH-1:0]   mem_din,
    output logic [DATA_WIDTH/8-1:0] mem_wstrb,
    input  logic [DATA_WIDTH-1:0]   mem_dout,
    input  logic                    mem_busy,
    output logic                    rsp_valid,
    output logic [DATA_WIDTH-1:0]   rsp_rdata,
    output logic                    rsp_err
);

    localparam int unsigned STRB_W = DATA_WIDTH / 8;
    localparam int unsigned HALF_W = DATA_WIDTH / 2;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    state_t                  r_state, w_next;
    logic                    r_we;
    logic [2:0]              r_f3;
    logic [1:0]              r_lane;

    logic                    r_req_ready, w_req_ready;
    logic                    r_mem_we, w_mem_we;
    logic                    r_mem_re, w_mem_re;
    logic [ADDR_WIDTH-1:0]   r_mem_addr, w_mem_addr;
    logic [DATA_WIDTH-1:0]   r_mem_din, w_mem_din;
    logic [STRB_W-1:0]       r_mem_wstrb, w_mem_wstrb;
    logic                    r_rsp_valid, w_rsp_valid;
    logic [DATA_WIDTH-1:0]   r_rsp_rdata, w_rsp_rdata;
    logic                    r_rsp_err, w_rsp_err;

    logic                    w_legal_f3, w_misaligned, w_req_err;
    logic [DATA_WIDTH-1:0]   w_st_din;
    logic [STRB_W-1:0]       w_st_strb;
    logic [7:0]              w_ld_byte;
    logic [15:0]             w_ld_half;
    logic [DATA_WIDTH-1:0]   w_ld_data;

    // Request legality: funct3 must suit the direction and the address its width.
    always_comb begin
        w_legal_f3 = 1'b0;
        case (req_funct3)
            3'b000, 3'b001, 3'b010: w_legal_f3 = 1'b1;
            3'b100, 3'b101:         w_legal_f3 = !req_we;
            default:                w_legal_f3 = 1'b0;
        endcase
        w_misaligned = ((req_funct3[1:0] == 2'b01) && req_addr[0]) ||
                       ((req_funct3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));
        w_req_err    = !w_legal_f3 || w_misaligned;
    end

    // Store steering: replicate the datum across lanes, enable only the addressed bytes.
    always_comb begin
        w_st_din  = req_wdata;
        w_st_strb = '1;
        case (req_funct3[1:0])
            2'b00: begin
                w_st_din  = {STRB_W{req_wdata[7:0]}};
                w_st_strb = STRB_W'(1) << req_addr[1:0];
            end
            2'b01: begin
                w_st_din  = {2{req_wdata[HALF_W-1:0]}};
                w_st_strb = STRB_W'(3) << req_addr[1:0];
            end
            default: ;
        endcase
    end

    // Load extraction from the word returned by memory.
    always_comb begin
        w_ld_byte = 8'(mem_dout >> {r_lane, 3'b000});
        w_ld_half = 16'(mem_dout >> {r_lane[1], 4'b0000});
        case (r_f3)
            3'b000:  w_ld_data = {{(DATA_WIDTH-8){w_ld_byte[7]}}, w_ld_byte};
            3'b001:  w_ld_data = {{(DATA_WIDTH-16){w_ld_half[15]}}, w_ld_half};
            3'b100:  w_ld_data = DATA_WIDTH'(w_ld_byte);
            3'b101:  w_ld_data = DATA_WIDTH'(w_ld_half);
            default: w_ld_data = mem_dout;
        endcase
    end

    // Next state and next values of every registered output.
    always_comb begin
        w_next      = r_state;
        w_mem_we    = 1'b0;
        w_mem_re    = 1'b0;
        w_mem_addr  = '0;
        w_mem_din   = '0;
        w_mem_wstrb = '0;
        w_rsp_valid = 1'b0;
        w_rsp_rdata = '0;
        w_rsp_err   = 1'b0;
        case (r_state)
            IDLE: begin
                if (req_valid) begin
                    if (w_req_err) begin
                        w_next      = RESP;
                        w_rsp_valid = 1'b1;
                        w_rsp_err   = 1'b1;
                    end else begin
                        w_next      = ISSUE;
                        w_mem_we    = req_we;
                        w_mem_re    = !req_we;
                        w_mem_addr  = {req_addr[ADDR_WIDTH-1:2], 2'b00};
                        w_mem_din   = req_we ? w_st_din : '0;
                        w_mem_wstrb = req_we ? w_st_strb : '0;
                    end
                end
            end
            ISSUE: begin
                if (mem_busy) begin
                    w_mem_we    = r_mem_we;
                    w_mem_re    = r_mem_re;
                    w_mem_addr  = r_mem_addr;
                    w_mem_din   = r_mem_din;
                    w_mem_wstrb = r_mem_wstrb;
                end else if (r_we) begin
                    w_next      = RESP;
                    w_rsp_valid = 1'b1;
                end else begin
                    w_next      = WAIT;
                end
            end
            WAIT: begin
                if (!mem_busy) begin
                    w_next      = RESP;
                    w_rsp_valid = 1'b1;
                    w_rsp_rdata = w_ld_data;
                end
            end
            RESP:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
        w_req_ready = (w_next == IDLE);
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_state     <= IDLE;
            r_we        <= 1'b0;
            r_f3        <= '0;
            r_lane      <= '0;
            r_req_ready <= 1'b1;
            r_mem_we    <= 1'b0;
            r_mem_re    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_din   <= '0;
            r_mem_wstrb <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp_rdata <= '0;
            r_rsp_err   <= 1'b0;
        end else begin
            r_state     <= w_next;
            r_req_ready <= w_req_ready;
            r_mem_we    <= w_mem_we;
            r_mem_re    <= w_mem_re;
            r_mem_addr  <= w_mem_addr;
            r_mem_din   <= w_mem_din;
            r_mem_wstrb <= w_mem_wstrb;
            r_rsp_valid <= w_rsp_valid;
            r_rsp_rdata <= w_rsp_rdata;
            r_rsp_err   <= w_rsp_err;
            if (r_state == IDLE && req_valid) begin
                r_we   <= req_we;
                r_f3   <= req_funct3;
                r_lane <= req_addr[1:0];
            end
        end
    end

    assign req_ready = r_req_ready;
    assign mem_we    = r_mem_we;
    assign mem_re    = r_mem_re;
    assign mem_addr  = r_mem_addr;
    assign mem_din   = r_mem_din;
    assign mem_wstrb = r_mem_wstrb;
    assign rsp_valid = r_rsp_valid;
    assign rsp_rdata = r_rsp_rdata;
    assign rsp_err   = r_rsp_err;

endmodule

// File: tb/tb_rip_mem_access.sv
// Scoreboard bench for rip_mem_access: driver pushes expected responses and
// memory accesses from a byte-level reference model; a negedge monitor checks them.
module tb_rip_mem_access;

    logic        clk;
    logic        rstn;
    logic        req_valid, req_ready, req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr, req_wdata;
    logic        mem_we, mem_re;
    logic [31:0] mem_addr, mem_din, mem_dout;
    logic [3:0]  mem_wstrb;
    logic        mem_busy;
    logic        rsp_valid, rsp_err;
    logic [31:0] rsp_rdata;

    rip_mem_access #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) dut (
        .clk(clk), .rstn(rstn),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
        .mem_we(mem_we), .mem_re(mem_re), .mem_addr(mem_addr), .mem_din(mem_din),
        .mem_wstrb(mem_wstrb), .mem_dout(mem_dout), .mem_busy(mem_busy),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
    );

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          acc;
        int          lat;
    } rsp_t;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] din;
        logic [3:0]  strb;
    } wr_t;

    typedef struct {
        logic        err;
        logic [31:0] rdata;
        int          lat;
        wr_t         wr;
    } model_t;

    rsp_t        sbq[$];
    wr_t         wq[$];
    logic [31:0] rq[$];

    int checks   = 0;
    int errors   = 0;
    int cyc      = 0;
    int next_acc = -1;
    bit mon_en   = 1'b0;

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    // Reference: byte-lane view of RV32I loads/stores.
    function automatic model_t model(input logic we, input logic [2:0] f3,
                                     input logic [31:0] addr, input logic [31:0] wdata,
                                     input logic [31:0] dout, input int n1, input int n2);
        model_t      m;
        int          size;
        int          lane;
        logic        legal;
        logic [31:0] v, mask;
        size  = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
        lane  = int'(addr[1:0]);
        legal = we ? (f3 <= 3'd2) : (f3 <= 3'd2 || f3 == 3'd4 || f3 == 3'd5);
        m.err      = !legal || (lane % size != 0);
        m.rdata    = '0;
        m.wr.addr  = addr & ~32'h3;
        m.wr.din   = '0;
        m.wr.strb  = '0;
        if (m.err) begin
            m.lat = 1;
        end else if (we) begin
            m.lat = 2 + n1;
            for (int i = 0; i < 4; i++) begin
                if (i >= lane && i < lane + size) m.wr.strb[i] = 1'b1;
                m.wr.din[8*i +: 8] = wdata[8*(i % size) +: 8];
            end
        end else begin
            m.lat = 3 + n1 + n2;
            v    = dout >> (8 * lane);
            mask = (size == 4) ? 32'hFFFF_FFFF : ((32'h1 << (8 * size)) - 32'h1);
            v    = v & mask;
            if (!f3[2] && size < 4 && v[8*size-1]) v = v | ~mask;
            m.rdata = v;
        end
        return m;
    endfunction

    // Drive one request; busy n1 cycles in ISSUE and n2 in WAIT; optional reset at cycle rst_at.
    task automatic do_txn(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [31:0] dout,
                          input int n1, input int n2, input int rst_at,
                          input logic use_exp, input logic [31:0] xr, input logic xe,
                          input int xlat);
        model_t m;
        rsp_t   e;
        int     a;
        int     guard;
        m = model(we, f3, addr, wdata, dout, n1, n2);
        req_valid  = 1'b1;
        req_we     = we;
        req_funct3 = f3;
        req_addr   = addr;
        req_wdata  = wdata;
        guard = 0;
        do begin
            @(negedge clk);
            guard++;
        end while (!req_ready && guard < 20);
        if (!req_ready) begin
            errors++; checks++;
            $display("FAIL accept_timeout got req_ready=%b required 1", req_ready);
            req_valid = 1'b0;
            return;
        end
        a = cyc;
        if (next_acc >= 0) begin
            checks++;
            if (a != next_acc) begin
                errors++;
                $display("FAIL accept_cycle got %0d required %0d", a, next_acc);
            end
        end
        e.acc   = a;
        e.rdata = use_exp ? xr : m.rdata;
        e.err   = use_exp ? xe : m.err;
        e.lat   = use_exp ? xlat : m.lat;
        sbq.push_back(e);
        if (!m.err && we)  wq.push_back(m.wr);
        if (!m.err && !we) rq.push_back(m.wr.addr);
        @(posedge clk); #1;
        req_valid  = 1'b0;
        req_we     = 1'($urandom);
        req_funct3 = 3'($urandom);
        req_addr   = $urandom;
        req_wdata  = $urandom;
        for (int k = 1; k < e.lat; k++) begin
            if (we) mem_busy = (k <= n1);
            else    mem_busy = (k <= n1) || (k > n1 + 1 && k <= n1 + 1 + n2);
            mem_dout = (!we && k == e.lat - 1) ? dout : $urandom;
            if (k == rst_at) rstn = 1'b0;
            @(posedge clk); #1;
            if (k == rst_at) begin
                checks++;
                if (req_ready !== 1'b1 || rsp_valid !== 1'b0 || rsp_rdata !== 32'h0 ||
                    rsp_err !== 1'b0 || mem_we !== 1'b0 || mem_re !== 1'b0 ||
                    mem_addr !== 32'h0 || mem_din !== 32'h0 || mem_wstrb !== 4'h0) begin
                    errors++;
                    $display("FAIL reset_mid_txn got rdy=%b rv=%b rd=%h re=%b we=%b mre=%b ma=%h md=%h ms=%h required rdy=1 others 0",
                             req_ready, rsp_valid, rsp_rdata, rsp_err, mem_we, mem_re,
                             mem_addr, mem_din, mem_wstrb);
                end
                rstn = 1'b1;
                void'(sbq.pop_back());
                next_acc = cyc;
                return;
            end
        end
        mem_busy = 1'($urandom);
        mem_dout = $urandom;
        next_acc = a + e.lat + 1;
    endtask

    // Monitor: responses against the scoreboard, strobes against expected accesses.
    always @(negedge clk) begin
        rsp_t e;
        if (mon_en) begin
            if (rsp_valid === 1'b1) begin
                checks++;
                if (sbq.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_rsp got rdata=%h err=%b required no response", rsp_rdata, rsp_err);
                end else begin
                    e = sbq.pop_front();
                    if (rsp_rdata !== e.rdata || rsp_err !== e.err || cyc - e.acc != e.lat) begin
                        errors++;
                        $display("FAIL rsp got rdata=%h err=%b lat=%0d required rdata=%h err=%b lat=%0d",
                                 rsp_rdata, rsp_err, cyc - e.acc, e.rdata, e.err, e.lat);
                    end
                end
            end else begin
                checks++;
                if (rsp_valid !== 1'b0 || rsp_rdata !== 32'h0 || rsp_err !== 1'b0) begin
                    errors++;
                    $display("FAIL rsp_quiet got valid=%b rdata=%h err=%b required 0", rsp_valid, rsp_rdata, rsp_err);
                end
            end
            if (mem_we === 1'b1 || mem_re === 1'b1) begin
                checks++;
                if (mem_we === 1'b1 && mem_re === 1'b1) begin
                    errors++;
                    $display("FAIL both_strobes got we=1 re=1 required one");
                end else if (mem_we === 1'b1) begin
                    if (wq.size() == 0) begin
                        errors++;
                        $display("FAIL unexpected_write got addr=%h required none", mem_addr);
                    end else begin
                        if (mem_addr !== wq[0].addr || mem_din !== wq[0].din || mem_wstrb !== wq[0].strb) begin
                            errors++;
                            $display("FAIL write got addr=%h din=%h strb=%b required addr=%h din=%h strb=%b",
                                     mem_addr, mem_din, mem_wstrb, wq[0].addr, wq[0].din, wq[0].strb);
                        end
                        if (!mem_busy) void'(wq.pop_front());
                    end
                end else begin
                    if (rq.size() == 0) begin
                        errors++;
                        $display("FAIL unexpected_read got addr=%h required none", mem_addr);
                    end else begin
                        if (mem_addr !== rq[0]) begin
                            errors++;
                            $display("FAIL read_addr got %h required %h", mem_addr, rq[0]);
                        end
                        if (!mem_busy) void'(rq.pop_front());
                    end
                end
            end
        end
    end

    initial begin
        logic        we;
        logic [2:0]  f3;
        logic [2:0]  legal_f3 [5];
        legal_f3[0] = 3'd0; legal_f3[1] = 3'd1; legal_f3[2] = 3'd2;
        legal_f3[3] = 3'd4; legal_f3[4] = 3'd5;
        rstn = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'd0;
        req_addr = '0; req_wdata = '0; mem_dout = '0; mem_busy = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (req_ready !== 1'b1 || rsp_valid !== 1'b0 || rsp_rdata !== 32'h0 || rsp_err !== 1'b0 ||
            mem_we !== 1'b0 || mem_re !== 1'b0 || mem_addr !== 32'h0 || mem_din !== 32'h0 ||
            mem_wstrb !== 4'h0) begin
            errors++;
            $display("FAIL reset_state got rdy=%b rv=%b we=%b re=%b required rdy=1 others 0",
                     req_ready, rsp_valid, mem_we, mem_re);
        end
        rstn = 1'b1;
        mon_en = 1'b1;
        next_acc = cyc;

        // LB sign extension, SH upper lanes, misaligned LW, LHU with stalls, two SW back-to-back
        do_txn(1'b0, 3'b000, 32'h0000_1003, 32'h0, 32'h80FF_0000, 0, 0, 0, 1'b1, 32'hFFFF_FF80, 1'b0, 3);
        do_txn(1'b1, 3'b001, 32'h0000_2002, 32'h0000_BEEF, 32'h0, 0, 0, 0, 1'b1, 32'h0, 1'b0, 2);
        do_txn(1'b0, 3'b010, 32'h0000_3001, 32'h0, 32'h1234_5678, 0, 0, 0, 1'b1, 32'h0, 1'b1, 1);
        do_txn(1'b0, 3'b101, 32'h0000_4002, 32'h0, 32'h8001_1234, 4, 2, 0, 1'b1, 32'h0000_8001, 1'b0, 9);
        do_txn(1'b1, 3'b010, 32'h0000_5000, 32'hCAFE_F00D, 32'h0, 0, 0, 0, 1'b1, 32'h0, 1'b0, 2);
        do_txn(1'b1, 3'b010, 32'h0000_5004, 32'h1357_9BDF, 32'h0, 0, 0, 0, 1'b1, 32'h0, 1'b0, 2);

        for (int t = 0; t < 120; t++) begin
            we = 1'($urandom);
            if ($urandom_range(0, 4) != 0)
                f3 = we ? 3'($urandom_range(0, 2)) : legal_f3[$urandom_range(0, 4)];
            else
                f3 = 3'($urandom);
            do_txn(we, f3, $urandom, $urandom, $urandom,
                   int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), 0,
                   1'b0, 32'h0, 1'b0, 0);
        end

        // Reset while waiting on a load, then a load right in the first cycle out of reset
        do_txn(1'b0, 3'b010, 32'h0000_6000, 32'h0, 32'hDEAD_BEEF, 0, 4, 3, 1'b0, 32'h0, 1'b0, 0);
        do_txn(1'b0, 3'b100, 32'h0000_7001, 32'h0, 32'h0000_9A00, 1, 1, 0, 1'b1, 32'h0000_009A, 1'b0, 5);

        req_valid = 1'b0;
        mem_busy  = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        checks++;
        if (sbq.size() != 0 || wq.size() != 0 || rq.size() != 0) begin
            errors++;
            $display("FAIL drain got rsp=%0d wr=%0d rd=%0d pending required 0", sbq.size(), wq.size(), rq.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/rip_mem_access.md
RIP_MEM_ACCESS -- requirements
Module: rip_mem_access

Interface
REQ-001 Parameters SHALL be: DATA_WIDTH, 32, data port width (only 32 supported); ADDR_WIDTH, 32, byte address width.
REQ-002 clk  input  1  sole clock; all state SHALL update on the rising edge.
REQ-003 rstn  input  1  reset, synchronous and active-low.
REQ-004 req_valid  input  1  pipeline presents a load/store request.
REQ-005 req_ready  output  1  block can accept a request this cycle.
REQ-006 req_we  input  1  1 = store, 0 = load.
REQ-007 req_funct3  input  3  RV32I width/sign code (LB=000, LH=001, LW=010, LBU=100, LHU=101; SB=000, SH=001, SW=010).
REQ-008 req_addr  input  ADDR_WIDTH  byte address.
REQ-009 req_wdata  input  DATA_WIDTH  store data, right-aligned.
REQ-010 mem_we / mem_re  output  1 each  write/read strobes to the byte-addressed memory.
REQ-011 mem_addr  output  ADDR_WIDTH  word-aligned address (addr[1:0] forced to 00).
REQ-012 mem_din  output  DATA_WIDTH  lane-shifted store data.
REQ-013 mem_wstrb  output  4  byte-lane write enables, bit i = byte i.
REQ-014 mem_dout  input  DATA_WIDTH  read word from memory.
REQ-015 mem_busy  input  1  memory cannot accept/complete this cycle.
REQ-016 rsp_valid  output  1  one-cycle completion pulse.
REQ-017 rsp_rdata  output  DATA_WIDTH  extended load result (0 for stores and errors).
REQ-018 rsp_err  output  1  misaligned or illegal funct3; valid with rsp_valid.

Function
REQ-019 FSM states SHALL be IDLE, ISSUE, WAIT, RESP; req_ready SHALL be 1 only in IDLE.
REQ-020 Request accepted on req_valid && req_ready; all req_* SHALL be registered at acceptance and held internally until RESP.
REQ-021 Error if funct3 not in legal set for req_we, or halfword with addr[0]=1, or word with addr[1:0]!=00; error request: IDLE -> RESP, no mem strobe ever asserted.
REQ-022 Legal request: IDLE -> ISSUE; in ISSUE mem_re (load) or mem_we (store) SHALL be 1 with mem_addr/mem_din/mem_wstrb stable.
REQ-023 ISSUE holds while mem_busy=1; on edge with mem_busy=0: store -> RESP, load -> WAIT; strobes deassert outside ISSUE.
REQ-024 WAIT: on first edge with mem_busy=0, mem_dout SHALL be captured and state -> RESP; WAIT holds while mem_busy=1.
REQ-025 RESP lasts exactly one cycle with rsp_valid=1, then -> IDLE; rsp_rdata/rsp_err valid only in that cycle, 0 otherwise.
REQ-026 Store lanes: SB wstrb=0001<<addr[1:0], mem_din = byte replicated x4; SH wstrb=0011<<addr[1:0], halfword replicated x2; SW wstrb=1111, din=wdata.
REQ-027 Load extract: byte = dout[8*addr[1:0]+:8], half = dout[16*addr[1]+:16]; LB/LH sign-extend, LBU/LHU zero-extend, LW unmodified.
REQ-028 Minimum latency (mem_busy=0): store acceptance -> rsp_valid 2 cycles; load 3 cycles; error 1 cycle.
REQ-029 Back-to-back: a new request SHALL be accepted in the cycle after RESP (IDLE); no request SHALL be lost or duplicated.
REQ-030 mem_busy changes outside ISSUE/WAIT SHALL have no effect.

Reset
REQ-031 rstn=0 at an edge SHALL force IDLE and zero every output except req_ready (1 after reset), including mid-ISSUE/WAIT; the in-flight request is dropped with no rsp_valid.
REQ-032 After release, first acceptance SHALL be possible in the first cycle with rstn=1.

Verification
REQ-033 LB addr=0x1003, mem_dout=0x80FF_0000, busy=0 -> rsp_valid 3 cycles after accept, rsp_rdata=0xFFFF_FF80, rsp_err=0.
REQ-034 SH addr=0x2002, wdata=0x0000_BEEF -> mem_we=1, mem_addr=0x2000, wstrb=1100, mem_din=0xBEEF_BEEF; rsp_valid 2 cycles later.
REQ-035 LW addr=0x3001 -> rsp_valid next cycle, rsp_err=1, rsp_rdata=0, mem_re/mem_we never 1.
REQ-036 LHU addr=0x4002, mem_busy=1 for 4 cycles in ISSUE and 2 in WAIT, mem_dout=0x8001_1234 -> strobes held, rsp_rdata=0x0000_8001 after 9 cycles.
REQ-037 Load accepted, rstn=0 during WAIT -> next cycle all outputs 0, req_ready=1 after release, no rsp_valid.
REQ-038 Two back-to-back SW with req_valid held -> second accepted the cycle after first rsp_valid; exactly two writes, two responses.
